// File: rtl/baser_257b_transcoder_pkg.sv
// Shared definitions for the 64B/66B -> 256B/257B transmit transcoder:
// block widths, sync-header codes, character patterns and the block class.
package baser_257b_transcoder_pkg;

    localparam int DATA_WIDTH    = 64;
    localparam int HDR_WIDTH     = 2;
    localparam int FRAME_WIDTH   = DATA_WIDTH + HDR_WIDTH;
    localparam int TC_DATA_WIDTH = 4 * DATA_WIDTH;
    localparam int TC_HDR_WIDTH  = 1;
    localparam int TC_WIDTH      = TC_DATA_WIDTH + TC_HDR_WIDTH;
    localparam int TC_BLOCKS     = 4;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    localparam logic [7:0] DATA_CHAR_PATTERN = 8'hAA;
    localparam logic [6:0] CTRL_CHAR_PATTERN = 7'h1E;
    localparam logic [3:0] OSET_CHAR_PATTERN = 4'hB;

    typedef enum logic [1:0] {
        DATA = 2'd0,
        CTRL = 2'd1,
        INV  = 2'd2
    } blk_class_t;

    // Classify a 66b block from its sync header; 00 and 11 are illegal.
    function automatic blk_class_t sh_class(input logic [HDR_WIDTH-1:0] sh);
        blk_class_t c;
        case (sh)
            SH_DATA: c = DATA;
            SH_CTRL: c = CTRL;
            default: c = INV;
        endcase
        return c;
    endfunction

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/baser_257b_transcoder_if.sv
// Stream bundle of the transcoder: 66b block input and 257b word output,
// each with its own valid/ready handshake.
interface baser_257b_transcoder_if;
    import baser_257b_transcoder_pkg::*;

    logic [FRAME_WIDTH-1:0] i_tx_coded;
    logic                   i_valid;
    logic                   o_ready;
    logic [TC_WIDTH-1:0]    o_tx_xcoded;
    logic                   o_valid;
    logic                   i_ready;

    // Transcoder side.
    modport slave (
        input  i_tx_coded,
        input  i_valid,
        output o_ready,
        output o_tx_xcoded,
        output o_valid,
        input  i_ready
    );

    // Source/sink side driving the transcoder.
    modport master (
        output i_tx_coded,
        output i_valid,
        input  o_ready,
        input  o_tx_xcoded,
        input  o_valid,
        output i_ready
    );

endinterface

// File: rtl/baser_257b_transcoder_pack.sv
// Combinational 256B/257B packer: four 64b payloads with their block classes
// in arrival order (block 0 first) produce one 257b transcoded word.
module baser_257b_transcoder_pack
    import baser_257b_transcoder_pkg::*;
(
    input  logic [TC_BLOCKS-1:0][DATA_WIDTH-1:0] payload_i,
    input  blk_class_t                           class_i [TC_BLOCKS],
    output logic [TC_WIDTH-1:0]                  xcoded_o
);

    logic [TC_DATA_WIDTH-1:0] flat;
    logic                     any_inv;
    logic                     all_data;
    logic                     ctrl_seen;
    logic [8:0]               pos;
    logic [TC_BLOCKS-1:0]     flags;

    assign flat = payload_i;

    // Build the 257b word: all-data, mixed data/control, or invalid-header codeword.
    always_comb begin
        xcoded_o  = '0;
        any_inv   = 1'b0;
        all_data  = 1'b1;
        ctrl_seen = 1'b0;
        pos       = 9'd5;
        flags     = '0;
        for (int i = 0; i < TC_BLOCKS; i++) begin
            if (class_i[i] == INV)  any_inv  = 1'b1;
            if (class_i[i] != DATA) all_data = 1'b0;
            flags[i] = (class_i[i] == DATA);
        end

        if (any_inv) begin
            // Flag nibble 1111 is never legal for a real control group, so the
            // downstream checker sees this as a sync-header error.
            xcoded_o = {flat[TC_WIDTH-6:0], 4'b1111, 1'b0};
        end else if (all_data) begin
            xcoded_o = {flat, 1'b1};
        end else begin
            xcoded_o[4:1] = flags;
            for (int i = 0; i < TC_BLOCKS; i++) begin
                if (class_i[i] == DATA) begin
                    xcoded_o[pos +: DATA_WIDTH] = payload_i[i];
                    pos = pos + 9'd64;
                end else if (!ctrl_seen) begin
                    // First control block: its type byte shrinks to the low nibble.
                    xcoded_o[pos +: 4]         = payload_i[i][3:0];
                    xcoded_o[pos + 9'd4 +: 56] = payload_i[i][DATA_WIDTH-1:8];
                    pos       = pos + 9'd60;
                    ctrl_seen = 1'b1;
                end else begin
                    xcoded_o[pos +: DATA_WIDTH] = payload_i[i];
                    pos = pos + 9'd64;
                end
            end
        end
    end

endmodule

// File: rtl/baser_257b_transcoder.sv
// Transmit 64B/66B -> 256B/257B transcoder top: slot buffer, fill index,
// single-entry output register, handshakes and saturating statistics.
module baser_257b_transcoder
    import baser_257b_transcoder_pkg::*;
(
    input  logic                   clk,
    input  logic                   i_rst,
    baser_257b_transcoder_if.slave bus,
    output logic [31:0]            o_block_count,
    output logic [31:0]            o_data_count,
    output logic [31:0]            o_ctrl_count,
    output logic [31:0]            o_inv_sh_count
);

    localparam int               IDX_W    = $clog2(TC_BLOCKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TC_BLOCKS - 1);

    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                ready_q;
    logic                valid_q, valid_d;
    logic [TC_WIDTH-1:0] xcoded_q, xcoded_d;
    logic [31:0]         blk_cnt_q, blk_cnt_d;
    logic [31:0]         data_cnt_q, data_cnt_d;
    logic [31:0]         ctrl_cnt_q, ctrl_cnt_d;
    logic [31:0]         inv_cnt_q, inv_cnt_d;

    logic [DATA_WIDTH-1:0] slot_q  [TC_BLOCKS-1];
    blk_class_t            class_q [TC_BLOCKS-1];

    logic                  accept;
    logic                  group_done;
    logic                  group_all_data;
    blk_class_t            in_class;
    logic [DATA_WIDTH-1:0] in_payload;

    logic [TC_BLOCKS-1:0][DATA_WIDTH-1:0] pack_payload;
    blk_class_t                           pack_class [TC_BLOCKS];
    logic [TC_WIDTH-1:0]                  pack_word;

    assign in_class   = sh_class(bus.i_tx_coded[HDR_WIDTH-1:0]);
    assign in_payload = bus.i_tx_coded[FRAME_WIDTH-1:HDR_WIDTH];

    // Only the 4th block needs a free output register; blocks 0..2 of the
    // next group keep filling while a finished word waits downstream.
    assign bus.o_ready = ready_q && !((idx_q == LAST_IDX) && valid_q && !bus.i_ready);
    assign accept      = bus.i_valid && bus.o_ready;
    assign group_done  = accept && (idx_q == LAST_IDX);

    assign bus.o_valid     = valid_q;
    assign bus.o_tx_xcoded = xcoded_q;
    assign o_block_count   = blk_cnt_q;
    assign o_data_count    = data_cnt_q;
    assign o_ctrl_count    = ctrl_cnt_q;
    assign o_inv_sh_count  = inv_cnt_q;

    // Feed the packer with the buffered slots plus the block arriving this cycle.
    always_comb begin
        pack_payload   = '0;
        group_all_data = 1'b1;
        for (int i = 0; i < TC_BLOCKS; i++) pack_class[i] = INV;
        for (int i = 0; i < TC_BLOCKS - 1; i++) begin
            pack_payload[i] = slot_q[i];
            pack_class[i]   = class_q[i];
        end
        pack_payload[TC_BLOCKS-1] = in_payload;
        pack_class[TC_BLOCKS-1]   = in_class;
        for (int i = 0; i < TC_BLOCKS; i++) begin
            if (pack_class[i] != DATA) group_all_data = 1'b0;
        end
    end

    baser_257b_transcoder_pack u_pack (
        .payload_i (pack_payload),
        .class_i   (pack_class),
        .xcoded_o  (pack_word)
    );

    // Next state: drain, fill index, output load and counter updates.
    always_comb begin
        idx_d      = idx_q;
        valid_d    = valid_q;
        xcoded_d   = xcoded_q;
        blk_cnt_d  = blk_cnt_q;
        data_cnt_d = data_cnt_q;
        ctrl_cnt_d = ctrl_cnt_q;
        inv_cnt_d  = inv_cnt_q;

        if (valid_q && bus.i_ready) valid_d = 1'b0;

        if (accept) begin
            idx_d = idx_q + 1'b1;
            if (in_class == INV) inv_cnt_d = sat_inc(inv_cnt_q);
        end

        // A load here may coincide with a drain above; the load wins, no bubble.
        if (group_done) begin
            valid_d   = 1'b1;
            xcoded_d  = pack_word;
            blk_cnt_d = sat_inc(blk_cnt_q);
            if (group_all_data) data_cnt_d = sat_inc(data_cnt_q);
            else                ctrl_cnt_d = sat_inc(ctrl_cnt_q);
        end
    end

    // Control, output register and statistics; reset drops partial and pending groups.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            idx_q      <= '0;
            ready_q    <= 1'b0;
            valid_q    <= 1'b0;
            xcoded_q   <= '0;
            blk_cnt_q  <= '0;
            data_cnt_q <= '0;
            ctrl_cnt_q <= '0;
            inv_cnt_q  <= '0;
        end else begin
            idx_q      <= idx_d;
            ready_q    <= 1'b1;
            valid_q    <= valid_d;
            xcoded_q   <= xcoded_d;
            blk_cnt_q  <= blk_cnt_d;
            data_cnt_q <= data_cnt_d;
            ctrl_cnt_q <= ctrl_cnt_d;
            inv_cnt_q  <= inv_cnt_d;
        end
    end

    // Slot buffer for blocks 0..2; the 4th block goes straight to the packer.
    always_ff @(posedge clk) begin
        if (accept && (idx_q != LAST_IDX)) begin
            slot_q[idx_q]  <= in_payload;
            class_q[idx_q] <= in_class;
        end
    end

endmodule

// File: tb/tb_baser_257b_transcoder.sv
// Self-checking bench for the 256B/257B transmit transcoder.
module tb_baser_257b_transcoder;
    import baser_257b_transcoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] blk_cnt, data_cnt, ctrl_cnt, inv_cnt;

    int errors = 0;
    int checks = 0;

    baser_257b_transcoder_if bus ();

    baser_257b_transcoder dut (
        .clk            (clk),
        .i_rst          (rst),
        .bus            (bus),
        .o_block_count  (blk_cnt),
        .o_data_count   (data_cnt),
        .o_ctrl_count   (ctrl_cnt),
        .o_inv_sh_count (inv_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state (written only by the monitor).
    logic [65:0]  grp [$];
    logic [256:0] exp_q [$];
    logic [256:0] last_word;
    logic [256:0] prev_word;
    bit           prev_stall;
    int           accepted  = 0;
    int           words_out = 0;
    int           m_blk = 0, m_data = 0, m_ctrl = 0, m_inv = 0;

    task automatic check_val(input string tag, input logic [256:0] got, input logic [256:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected 257b word straight from the grouping rules.
    function automatic logic [256:0] model_xcode(input logic [3:0][65:0] g);
        logic [319:0] acc;
        logic [63:0]  p;
        int           pos;
        bit           inv, alldata, seen;
        inv = 0; alldata = 1; seen = 0; acc = '0; pos = 5;
        for (int i = 0; i < 4; i++) begin
            if (g[i][1:0] == 2'b00 || g[i][1:0] == 2'b11) inv = 1;
            if (g[i][1:0] != 2'b01) alldata = 0;
        end
        if (inv || alldata) begin
            for (int i = 0; i < 4; i++) acc |= 320'(g[i][65:2]) << (64 * i);
            if (inv) return {acc[251:0], 4'b1111, 1'b0};
            return {acc[255:0], 1'b1};
        end
        for (int i = 0; i < 4; i++) begin
            p = g[i][65:2];
            if (g[i][1:0] == 2'b01) begin
                acc[i+1] = 1'b1;
                acc |= 320'(p) << pos;
                pos += 64;
            end else if (!seen) begin
                acc |= 320'({p[63:8], p[3:0]}) << pos;
                pos += 60;
                seen = 1;
            end else begin
                acc |= 320'(p) << pos;
                pos += 64;
            end
        end
        return acc[256:0];
    endfunction

    // Monitor: samples on the falling edge, tracks accepts and scores outputs.
    always @(negedge clk) begin
        logic [3:0][65:0] g;
        logic [256:0]     e;
        if (rst) begin
            grp.delete();
            exp_q.delete();
            m_blk = 0; m_data = 0; m_ctrl = 0; m_inv = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check_val("hold_valid", bus.o_valid, 1);
                check_val("hold_word", bus.o_tx_xcoded, prev_word);
            end
            if (bus.o_valid && bus.i_ready) begin
                check_val("out_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_val("out_word", bus.o_tx_xcoded, e);
                end
                last_word = bus.o_tx_xcoded;
                words_out++;
            end
            prev_stall = bus.o_valid && !bus.i_ready;
            prev_word  = bus.o_tx_xcoded;
            if (bus.i_valid && bus.o_ready) begin
                grp.push_back(bus.i_tx_coded);
                if (bus.i_tx_coded[1:0] == 2'b00 || bus.i_tx_coded[1:0] == 2'b11) m_inv++;
                accepted++;
                if (grp.size() == 4) begin
                    for (int i = 0; i < 4; i++) g[i] = grp[i];
                    e = model_xcode(g);
                    exp_q.push_back(e);
                    m_blk++;
                    if (e[0]) m_data++;
                    else      m_ctrl++;
                    grp.delete();
                end
            end
        end
    end

    function automatic logic [65:0] mk(input logic [1:0] sh, input logic [63:0] p);
        return {p, sh};
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Hold a block on the input until it is accepted (bounded).
    task automatic send_block(input logic [65:0] b);
        int n0;
        bit ok;
        n0 = accepted;
        ok = 0;
        bus.i_valid    = 1'b1;
        bus.i_tx_coded = b;
        for (int t = 0; t < 50; t++) begin
            @(posedge clk); #1;
            if (accepted != n0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check_val("send_timeout", accepted - n0, 1);
    endtask

    task automatic idle();
        bus.i_valid = 1'b0;
    endtask

    task automatic drain();
        bus.i_ready = 1'b1;
        for (int t = 0; t < 100; t++) begin
            if (exp_q.size() == 0 && !bus.o_valid) break;
            @(posedge clk); #1;
        end
        check_val("drain_empty", exp_q.size(), 0);
    endtask

    task automatic check_counters(input string tag);
        check_val({tag, "_blk"},  blk_cnt,  m_blk);
        check_val({tag, "_data"}, data_cnt, m_data);
        check_val({tag, "_ctrl"}, ctrl_cnt, m_ctrl);
        check_val({tag, "_inv"},  inv_cnt,  m_inv);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] aa, p0, p1, p2, p3;
        logic [65:0] bp [8];
        logic [65:0] b;
        int n0, w0, k;

        aa = {8{DATA_CHAR_PATTERN}};
        rst = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_tx_coded = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_valid", bus.o_valid, 0);
        check_val("rst_ready", bus.o_ready, 0);
        check_val("rst_word", bus.o_tx_xcoded, 0);
        check_val("rst_cnt", {blk_cnt, data_cnt, ctrl_cnt, inv_cnt}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_val("rel_ready_before_clk", bus.o_ready, 0);
        @(posedge clk); #1;
        check_val("rel_ready_after_clk", bus.o_ready, 1);

        // Four data blocks
        bus.i_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_block(mk(SH_DATA, aa));
        idle();
        check_val("t1_latency_valid", bus.o_valid, 1);
        check_val("t1_word", bus.o_tx_xcoded, {{32{8'hAA}}, 1'b1});
        drain();
        check_val("t1_data_cnt", data_cnt, 1);
        check_counters("t1");

        // Control 0x78 then three data
        send_block(mk(SH_CTRL, {{7{8'hAA}}, 8'h78}));
        for (int i = 0; i < 3; i++) send_block(mk(SH_DATA, aa));
        idle();
        drain();
        check_val("t2_b0", last_word[0], 0);
        check_val("t2_flags", last_word[4:1], 4'b1110);
        check_val("t2_nib", last_word[8:5], 4'h8);
        check_val("t2_ctrl56", last_word[64:9], {7{8'hAA}});
        check_val("t2_data", last_word[256:65], {24{8'hAA}});
        check_val("t2_ctrl_cnt", ctrl_cnt, 1);

        // D / C 0xFF / D / C 0x87
        send_block(mk(SH_DATA, rnd64()));
        send_block(mk(SH_CTRL, {rnd64() >> 8, 8'hFF}));
        send_block(mk(SH_DATA, rnd64()));
        send_block(mk(SH_CTRL, {rnd64() >> 8, 8'h87}));
        idle();
        drain();
        check_val("t3_b0", last_word[0], 0);
        check_val("t3_flags", last_word[4:1], 4'b0101);
        check_val("t3_nib", last_word[72:69], 4'hF);
        check_val("t3_type", last_word[200:193], 8'h87);

        // Invalid sync header on block 2
        p0 = rnd64(); p1 = rnd64(); p2 = rnd64(); p3 = rnd64();
        send_block(mk(SH_DATA, p0));
        send_block(mk(SH_DATA, p1));
        send_block(mk(2'b11, p2));
        send_block(mk(SH_DATA, p3));
        idle();
        drain();
        check_val("t4_b0", last_word[0], 0);
        check_val("t4_flags", last_word[4:1], 4'b1111);
        check_val("t4_payload", last_word[256:5], {p3[59:0], p2, p1, p0});
        check_val("t4_inv_cnt", inv_cnt, 1);
        check_val("t4_ctrl_cnt", ctrl_cnt, 3);
        check_counters("t4");

        // Backpressure with a continuous stream
        for (int i = 0; i < 8; i++) bp[i] = mk(SH_DATA, rnd64());
        w0 = words_out;
        n0 = accepted;
        bus.i_ready = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_tx_coded = bp[0];
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            k = accepted - n0;
            if (k < 8) bus.i_tx_coded = bp[k];
        end
        check_val("t5_accepted", accepted - n0, 7);
        check_val("t5_ready_low", bus.o_ready, 0);
        check_val("t5_valid", bus.o_valid, 1);
        bus.i_ready = 1'b1;
        for (int t = 0; t < 20; t++) begin
            if (accepted - n0 >= 8) break;
            @(posedge clk); #1;
        end
        idle();
        check_val("t5_all_accepted", accepted - n0, 8);
        drain();
        check_val("t5_words", words_out - w0, 2);

        // Reset in the middle of a group
        send_block(mk(SH_DATA, rnd64()));
        send_block(mk(SH_CTRL, rnd64()));
        idle();
        rst = 1'b1;
        @(negedge clk);
        check_val("t6_rst_ready", bus.o_ready, 0);
        check_val("t6_rst_cnt", blk_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        w0 = words_out;
        p0 = rnd64(); p1 = rnd64(); p2 = rnd64(); p3 = rnd64();
        send_block(mk(SH_DATA, p0));
        send_block(mk(SH_DATA, p1));
        send_block(mk(SH_DATA, p2));
        send_block(mk(SH_DATA, p3));
        idle();
        drain();
        check_val("t6_words", words_out - w0, 1);
        check_val("t6_word", last_word, {p3, p2, p1, p0, 1'b1});
        check_val("t6_blk_cnt", blk_cnt, 1);

        // Randomized traffic with random backpressure
        n0 = accepted;
        b = mk(SH_DATA, rnd64());
        k = accepted;
        for (int c = 0; c < 3000; c++) begin
            if (accepted - n0 >= 240) break;
            if (accepted != k) begin
                k = accepted;
                case ($urandom_range(0, 19))
                    0:              b = mk(($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00, rnd64());
                    1, 2:           b = mk(SH_CTRL, {{8{CTRL_CHAR_PATTERN}}, 8'h1E});
                    3, 4:           b = mk(SH_CTRL, {28'($urandom()), OSET_CHAR_PATTERN, 24'($urandom()), 8'h4B});
                    5, 6:           b = mk(SH_CTRL, rnd64());
                    7:              b = mk(SH_DATA, aa);
                    default:        b = mk(SH_DATA, rnd64());
                endcase
            end
            bus.i_tx_coded = b;
            bus.i_valid = ($urandom_range(0, 3) != 0);
            bus.i_ready = ($urandom_range(0, 9) < 6);
            @(posedge clk); #1;
        end
        idle();
        check_val("t7_accepted", accepted - n0, 240);
        drain();
        check_val("t7_grp_empty", grp.size(), 0);
        check_counters("t7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
